// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: single-outstanding instruction fetch from the PC unit to decode over an SRAM-like bus
module inst_fetch_bridge #(
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetch_pc,
   input  logic        fetch_req,
   input  logic        flush,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        inst_valid,
   input  logic        inst_accept,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic        inst_adel,
   output logic        pc_advance
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DISCARD} state_t;
   state_t state, state_nxt;
   logic   kill;
   logic   aligned;
   logic   start;
   assign aligned    = fetch_pc[1:0] == 2'b00;
   assign start      = state == IDLE && fetch_req && !flush;
   assign inst_req   = state == REQ;
   assign inst_valid = state == HOLD;
   assign pc_advance = inst_valid && inst_accept && !flush;
   // next state: a flushed read that still owes a response parks in DISCARD until data_ok
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? (aligned ? REQ : HOLD) : IDLE;
         REQ:     state_nxt = inst_addr_ok ? ((flush || kill) ? DISCARD : WAIT) : REQ;
         WAIT:    state_nxt = inst_data_ok ? (flush ? IDLE : HOLD) : (flush ? DISCARD : WAIT);
         HOLD:    state_nxt = (inst_accept || flush) ? IDLE : HOLD;
         DISCARD: state_nxt = inst_data_ok ? IDLE : DISCARD;
         default: state_nxt = IDLE;
      endcase
   end
   // state, sticky kill for flushes seen before the address is taken, and the captured fetch context
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         kill      <= 1'b0;
         inst_addr <= '0;
         inst_pc   <= '0;
         inst_out  <= '0;
         inst_adel <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == REQ) kill <= inst_addr_ok ? 1'b0 : (kill || flush);
         if (start) begin
            inst_pc   <= fetch_pc;
            inst_adel <= !aligned;
            if (aligned) inst_addr <= fetch_pc;
            else inst_out <= NOP_WORD;
         end
         if (state == WAIT && inst_data_ok && !flush) begin
            inst_out  <= inst_rdata;
            inst_adel <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb_inst_fetch_bridge: vector table, hand-written corner sequences and a randomized scoreboard run
module tb_inst_fetch_bridge;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] fetch_pc = '0;
   logic        fetch_req = 1'b0;
   logic        flush = 1'b0;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = '0;
   logic        inst_valid;
   logic        inst_accept = 1'b0;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_adel;
   logic        pc_advance;
   int checks = 0;
   int failures = 0;
   int val_cnt = 0;
   int adv_cnt = 0;
   inst_fetch_bridge dut (
      .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_req(fetch_req), .flush(flush),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_valid(inst_valid),
      .inst_accept(inst_accept), .inst_out(inst_out), .inst_pc(inst_pc),
      .inst_adel(inst_adel), .pc_advance(pc_advance)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] rdata;
      logic [31:0] out;
      logic        adel;
      int          lat;
   } vec_t;
   vec_t vecs[6];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask
   task automatic cyc(input logic fr, input logic fl, input logic acc, input logic aok, input logic dok, input logic [31:0] rd);
      @(posedge clk);
      #1;
      fetch_req = fr;
      flush = fl;
      inst_accept = acc;
      inst_addr_ok = aok;
      inst_data_ok = dok;
      inst_rdata = rd;
      #4;
      if (inst_valid) val_cnt++;
      if (pc_advance) adv_cnt++;
   endtask
   task automatic run_vec(input vec_t v, input string tag);
      int  vcyc = -1;
      int  rcyc = -1;
      int  acyc = -1;
      int  nval = 0;
      int  nadv = 0;
      bit  pend = 0;
      fetch_pc = v.pc;
      cyc(1, 0, 1, 0, 0, 32'h0);
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk);
         #1;
         fetch_req = 0;
         flush = 0;
         inst_accept = 1;
         inst_addr_ok = inst_req;
         inst_data_ok = pend;
         inst_rdata = pend ? v.rdata : 32'hFFFF_0000;
         #4;
         if (inst_req && rcyc < 0) rcyc = c;
         if (inst_valid) begin
            nval++;
            if (vcyc < 0) begin
               vcyc = c;
               check({tag, ".out"}, inst_out, v.out);
               check({tag, ".pc"}, inst_pc, v.pc);
               check({tag, ".adel"}, {31'b0, inst_adel}, {31'b0, v.adel});
            end
         end
         if (pc_advance) begin
            nadv++;
            acyc = c;
         end
         if (inst_data_ok) pend = 0;
         if (inst_req && inst_addr_ok) pend = 1;
      end
      check({tag, ".lat"}, vcyc, v.lat);
      check({tag, ".req_cyc"}, rcyc, v.adel ? -1 : 1);
      check({tag, ".nvalid"}, nval, 1);
      check({tag, ".nadv"}, nadv, 1);
      check({tag, ".adv_cyc"}, acyc, v.lat);
   endtask
   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a * 32'h9E37_79B1 ^ 32'h0000_1234;
   endfunction
   function automatic logic [31:0] pick(input logic [31:0] base);
      logic [1:0] lo;
      lo = ($urandom % 8 == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      return {base[31:2], lo};
   endfunction
   logic [31:0] pc, paddr, prev_addr;
   bit          pend, prev_req, prev_aok;
   int          deliv, v0, a0;
   initial begin
      vecs[0] = '{32'hBFC0_0000, 32'h2401_0001, 32'h2401_0001, 1'b0, 3};
      vecs[1] = '{32'hBFC0_0002, 32'h1111_1111, 32'h0000_0000, 1'b1, 1};
      vecs[2] = '{32'h8000_0180, 32'h1234_5678, 32'h1234_5678, 1'b0, 3};
      vecs[3] = '{32'h0000_0001, 32'h2222_2222, 32'h0000_0000, 1'b1, 1};
      vecs[4] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3};
      vecs[5] = '{32'h0000_0003, 32'h3333_3333, 32'h0000_0000, 1'b1, 1};
      rst = 1;
      repeat (3) cyc(0, 0, 0, 0, 0, 32'h0);
      check("rst.req", {31'b0, inst_req}, 0);
      check("rst.valid", {31'b0, inst_valid}, 0);
      check("rst.adel", {31'b0, inst_adel}, 0);
      check("rst.adv", {31'b0, pc_advance}, 0);
      check("rst.addr", inst_addr, 0);
      check("rst.out", inst_out, 0);
      check("rst.pc", inst_pc, 0);
      rst = 0;
      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
      // delayed addr_ok then delayed data_ok
      fetch_pc = 32'h8000_1000;
      v0 = val_cnt;
      a0 = adv_cnt;
      cyc(1, 0, 1, 0, 0, 32'h0);
      for (int c = 1; c <= 3; c++) begin
         cyc(0, 0, 1, 0, 0, 32'h0);
         check("slow.req", {31'b0, inst_req}, 1);
         check("slow.addr", inst_addr, 32'h8000_1000);
      end
      cyc(0, 0, 1, 1, 0, 32'h0);
      check("slow.addr_ok_addr", inst_addr, 32'h8000_1000);
      cyc(0, 0, 1, 0, 0, 32'h0);
      check("slow.req_drop", {31'b0, inst_req}, 0);
      cyc(0, 0, 1, 0, 1, 32'hA5A5_0001);
      cyc(0, 0, 1, 0, 0, 32'h0);
      check("slow.out", inst_out, 32'hA5A5_0001);
      check("slow.pc", inst_pc, 32'h8000_1000);
      cyc(0, 0, 1, 0, 0, 32'h0);
      check("slow.nvalid", val_cnt - v0, 1);
      check("slow.nadv", adv_cnt - a0, 1);
      // flush in WAIT, late response dropped, next fetch returns its own data
      fetch_pc = 32'h8000_0100;
      v0 = val_cnt;
      cyc(1, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, 0, 1, 0, 32'h0);
      cyc(0, 1, 0, 0, 0, 32'h0);
      fetch_pc = 32'h8000_0180;
      cyc(1, 0, 0, 0, 0, 32'h0);
      check("wflush.disc_req", {31'b0, inst_req}, 0);
      cyc(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
      check("wflush.disc_req2", {31'b0, inst_req}, 0);
      cyc(1, 0, 0, 0, 0, 32'h0);
      check("wflush.idle_req", {31'b0, inst_req}, 0);
      check("wflush.novalid", val_cnt - v0, 0);
      cyc(0, 0, 0, 1, 0, 32'h0);
      check("wflush.req", {31'b0, inst_req}, 1);
      check("wflush.addr", inst_addr, 32'h8000_0180);
      cyc(0, 0, 0, 0, 1, 32'h3C1A_8000);
      cyc(0, 0, 1, 0, 0, 32'h0);
      check("wflush.valid", {31'b0, inst_valid}, 1);
      check("wflush.out", inst_out, 32'h3C1A_8000);
      check("wflush.pc", inst_pc, 32'h8000_0180);
      check("wflush.adv", {31'b0, pc_advance}, 1);
      // flush in REQ before addr_ok
      fetch_pc = 32'h8000_0200;
      v0 = val_cnt;
      a0 = adv_cnt;
      cyc(1, 0, 1, 0, 0, 32'h0);
      cyc(0, 1, 1, 0, 0, 32'h0);
      check("rflush.req", {31'b0, inst_req}, 1);
      cyc(0, 0, 1, 0, 0, 32'h0);
      check("rflush.req_held", {31'b0, inst_req}, 1);
      check("rflush.addr_held", inst_addr, 32'h8000_0200);
      cyc(0, 0, 1, 1, 0, 32'h0);
      cyc(0, 0, 1, 0, 0, 32'h0);
      check("rflush.req_off", {31'b0, inst_req}, 0);
      cyc(0, 0, 1, 0, 1, 32'h1111_1111);
      cyc(0, 0, 1, 0, 0, 32'h0);
      cyc(0, 0, 1, 0, 0, 32'h0);
      check("rflush.novalid", val_cnt - v0, 0);
      check("rflush.noadv", adv_cnt - a0, 0);
      run_vec('{32'h8000_0204, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 3}, "after_kill");
      // HOLD stall, then flush with accept, then reset in WAIT
      fetch_pc = 32'h8000_0300;
      a0 = adv_cnt;
      cyc(1, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, 0, 1, 0, 32'h0);
      cyc(0, 0, 0, 0, 1, 32'h8C42_0004);
      for (int c = 0; c < 4; c++) begin
         cyc(0, 0, 0, 0, 0, 32'h0);
         check("stall.valid", {31'b0, inst_valid}, 1);
         check("stall.out", inst_out, 32'h8C42_0004);
         check("stall.pc", inst_pc, 32'h8000_0300);
      end
      cyc(0, 1, 1, 0, 0, 32'h0);
      check("stall.flush_adv", {31'b0, pc_advance}, 0);
      cyc(0, 0, 0, 0, 0, 32'h0);
      check("stall.dropped", {31'b0, inst_valid}, 0);
      check("stall.noadv", adv_cnt - a0, 0);
      fetch_pc = 32'h8000_0400;
      cyc(1, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, 0, 1, 0, 32'h0);
      cyc(0, 0, 0, 0, 0, 32'h0);
      rst = 1;
      cyc(0, 0, 0, 0, 0, 32'h0);
      check("rstw.req", {31'b0, inst_req}, 0);
      check("rstw.valid", {31'b0, inst_valid}, 0);
      check("rstw.adel", {31'b0, inst_adel}, 0);
      check("rstw.addr", inst_addr, 0);
      check("rstw.out", inst_out, 0);
      check("rstw.pc", inst_pc, 0);
      rst = 0;
      cyc(0, 0, 1, 0, 1, 32'h9999_9999);
      cyc(0, 0, 1, 0, 0, 32'h0);
      check("rstw.late_valid", {31'b0, inst_valid}, 0);
      check("rstw.late_out", inst_out, 0);
      // randomized run against a transaction-level scoreboard
      pc = 32'h8000_0000;
      pend = 0;
      prev_req = 0;
      prev_aok = 0;
      prev_addr = '0;
      deliv = 0;
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         fetch_pc = pc;
         fetch_req = ($urandom % 4 != 0);
         flush = ($urandom % 14 == 0);
         inst_accept = $urandom % 2;
         inst_addr_ok = inst_req && !pend && ($urandom % 3 != 0);
         inst_data_ok = pend && ($urandom % 3 == 0);
         inst_rdata = inst_data_ok ? word_of(paddr) : $urandom;
         #4;
         if (inst_req && pend) check("rand.one_outstanding", {31'b0, inst_req}, 0);
         if (prev_req && !prev_aok) begin
            check("rand.req_held", {31'b0, inst_req}, 1);
            check("rand.addr_held", inst_addr, prev_addr);
         end
         if (inst_valid) begin
            check("rand.pc", inst_pc, pc);
            check("rand.adel", {31'b0, inst_adel}, {31'b0, pc[1:0] != 2'b00});
            check("rand.out", inst_out, pc[1:0] != 2'b00 ? 32'h0 : word_of(pc));
         end
         check("rand.adv", {31'b0, pc_advance}, {31'b0, inst_valid && inst_accept && !flush});
         if (pc_advance) deliv++;
         if (inst_data_ok) pend = 0;
         if (inst_req && inst_addr_ok) begin
            pend = 1;
            paddr = inst_addr;
         end
         prev_req = inst_req;
         prev_aok = inst_addr_ok;
         prev_addr = inst_addr;
         if (flush) pc = pick((pc & ~32'h3) + 32'h100 + ($urandom % 16) * 16);
         else if (inst_valid && inst_accept) pc = pick((pc & ~32'h3) + 32'h4);
      end
      check("rand.deliveries", {31'b0, deliv >= 50}, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
